// File: rtl/sha256_cnter.sv
// Iterative SHA-256 compression core, one round per clock (64 rounds).
// Define SHA256_CNTER_WCAP_EN to capture the message schedule at load time.
module sha256_cnter (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:7][31:0] H_in,
    input  logic [0:63][31:0] W,
    output logic [0:255]     H_out,
    output logic             done
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_ROUND,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [0:7][31:0] wv_q, wv_d;
    logic [0:7][31:0] base_q, base_d;
    logic [0:7][31:0] hout_q, hout_d;
    logic             done_q, done_d;

`ifdef SHA256_CNTER_WCAP_EN
    logic [0:63][31:0] wsch_q, wsch_d;
`endif

    logic [31:0] w_cur;
    logic [31:0] k_cur;
    logic [31:0] big0, big1, ch, maj, t1, t2;

    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        logic [31:0] k;
        unique case (idx)
            6'd0:  k = 32'h428a2f98;
            6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;
            6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;
            6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;
            6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;
            6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;
            6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;
            6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;
            6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;
            6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;
            6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;
            6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;
            6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;
            6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;
            6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;
            6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;
            6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;
            6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;
            6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;
            6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;
            6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;
            6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;
            6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;
            6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;
            6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;
            6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;
            6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;
            6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;
            6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;
            6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;
            6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;
            6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;
            6'd63: k = 32'hc67178f2;
            default: k = 32'h0;
        endcase
        return k;
    endfunction

`ifdef SHA256_CNTER_WCAP_EN
    assign w_cur = wsch_q[cnt_q];
`else
    assign w_cur = W[cnt_q];
`endif

    assign k_cur = k_rom(cnt_q);

    // Round datapath: wv_q[0..7] hold working variables a..h
    always_comb begin
        big0 = {wv_q[0][1:0],  wv_q[0][31:2]}
             ^ {wv_q[0][12:0], wv_q[0][31:13]}
             ^ {wv_q[0][21:0], wv_q[0][31:22]};
        big1 = {wv_q[4][5:0],  wv_q[4][31:6]}
             ^ {wv_q[4][10:0], wv_q[4][31:11]}
             ^ {wv_q[4][24:0], wv_q[4][31:25]};
        ch   = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
        maj  = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2])
             ^ (wv_q[1] & wv_q[2]);
        t1   = wv_q[7] + big1 + ch + k_cur + w_cur;
        t2   = big0 + maj;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wv_d    = wv_q;
        base_d  = base_q;
        hout_d  = hout_q;
        done_d  = done_q;
`ifdef SHA256_CNTER_WCAP_EN
        wsch_d  = wsch_q;
`endif
        unique case (state_q)
            S_LOAD: begin
                wv_d    = H_in;
                base_d  = H_in;
                cnt_d   = 6'd0;
                state_d = S_ROUND;
`ifdef SHA256_CNTER_WCAP_EN
                wsch_d  = W;
`endif
            end
            S_ROUND: begin
                wv_d[0] = t1 + t2;
                wv_d[1] = wv_q[0];
                wv_d[2] = wv_q[1];
                wv_d[3] = wv_q[2];
                wv_d[4] = wv_q[3] + t1;
                wv_d[5] = wv_q[4];
                wv_d[6] = wv_q[5];
                wv_d[7] = wv_q[6];
                cnt_d   = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    for (int i = 0; i < 8; i++) begin
                        hout_d[i] = base_q[i] + wv_d[i];
                    end
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LOAD;
            cnt_q   <= 6'd0;
            wv_q    <= '0;
            base_q  <= '0;
            hout_q  <= '0;
            done_q  <= 1'b0;
`ifdef SHA256_CNTER_WCAP_EN
            wsch_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wv_q    <= wv_d;
            base_q  <= base_d;
            hout_q  <= hout_d;
            done_q  <= done_d;
`ifdef SHA256_CNTER_WCAP_EN
            wsch_q  <= wsch_d;
`endif
        end
    end

    assign H_out = hout_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sha256_cnter.sv
// Scoreboard bench for sha256_cnter: known digests plus a reference model.
// Define SHA256_CNTER_WCAP_EN to also scramble W after the load edge.
module tb_sha256_cnter;

    logic              clk;
    logic              reset;
    logic [0:7][31:0]  h_in;
    logic [0:63][31:0] w_in;
    logic [0:255]      h_out;
    logic              done;

    sha256_cnter dut (
        .clk   (clk),
        .reset (reset),
        .H_in  (h_in),
        .W     (w_in),
        .H_out (h_out),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    int n_cmp = 0;
    int n_bad = 0;

    logic [255:0] exp_q [$];
    logic [31:0]  hv [8];
    logic [31:0]  m16 [16];
    logic [31:0]  wx [64];

    task automatic check(input string tag,
                         input logic [255:0] got,
                         input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] xx;
        xx = {x, x} >> n;
        return xx[31:0];
    endfunction

    // Expand m16 into wx and drive both ports
    task automatic apply_inputs();
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                wx[t] = m16[t];
            end else begin
                s0 = rotr(wx[t-15], 7) ^ rotr(wx[t-15], 18) ^ (wx[t-15] >> 3);
                s1 = rotr(wx[t-2], 17) ^ rotr(wx[t-2], 19) ^ (wx[t-2] >> 10);
                wx[t] = s1 + wx[t-7] + s0 + wx[t-16];
            end
        end
        for (int i = 0; i < 8; i++) h_in[i] = hv[i];
        for (int t = 0; t < 64; t++) w_in[t] = wx[t];
    endtask

    function automatic logic [255:0] model();
        logic [31:0] v [8];
        logic [31:0] t1, t2, e1, a0, chv, mjv;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) v[i] = hv[i];
        for (int t = 0; t < 64; t++) begin
            e1  = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
            chv = (v[4] & v[5]) ^ (~v[4] & v[6]);
            t1  = v[7] + e1 + chv + KT[t] + wx[t];
            a0  = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
            mjv = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
            t2  = a0 + mjv;
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        r = '0;
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[i] + v[i];
        return r;
    endfunction

    task automatic set_msg(input logic [31:0] w0, input logic [31:0] w15);
        for (int i = 0; i < 16; i++) m16[i] = 32'h0;
        m16[0]  = w0;
        m16[15] = w15;
        for (int i = 0; i < 8; i++) hv[i] = IV[i];
    endtask

    // Count edges after release until done; then pop and compare
    task automatic wait_done(input string tag);
        int n;
        bit seen;
        logic [255:0] e;
        n = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) seen = 1'b1;
`ifdef SHA256_CNTER_WCAP_EN
            if (!seen) begin
                for (int t = 0; t < 64; t++) w_in[t] = $urandom;
            end
`endif
        end
        check({tag, "_latency"}, 256'(n), 256'(65));
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 256'(0), 256'(1));
        end else begin
            e = exp_q.pop_front();
            check({tag, "_digest"}, h_out, e);
        end
    endtask

    task automatic run_block(input string tag, input logic [255:0] e);
        @(negedge clk);
        reset = 1'b1;
        apply_inputs();
        @(negedge clk);
        exp_q.push_back(e);
        reset = 1'b0;
        wait_done(tag);
    endtask

    initial begin
        reset = 1'b1;
        h_in  = '0;
        w_in  = '0;
        repeat (2) @(negedge clk);
        check("rst_hout", h_out, 256'h0);
        check("rst_done", 256'(done), 256'h0);

        set_msg(32'h80000000, 32'h0);
        run_block("empty", DIG_EMPTY);

        set_msg(32'h61626380, 32'h00000018);
        run_block("abc", DIG_ABC);

        set_msg(32'h87027980, 32'h00000018);
        apply_inputs();
        run_block("msg3", model());

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) hv[i] = $urandom;
            for (int i = 0; i < 16; i++) m16[i] = $urandom;
            apply_inputs();
            run_block($sformatf("rand%0d", k), model());
        end

        // Abort at round 30 and restart with the same block
        set_msg(32'h61626380, 32'h00000018);
        @(negedge clk);
        reset = 1'b1;
        apply_inputs();
        @(negedge clk);
        reset = 1'b0;
        repeat (31) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_hout", h_out, 256'h0);
        check("midrst_done", 256'(done), 256'h0);
        @(negedge clk);
        check("midrst_hout2", h_out, 256'h0);
        check("midrst_done2", 256'(done), 256'h0);
        exp_q.push_back(DIG_ABC);
        reset = 1'b0;
        wait_done("restart_abc");

        // Inputs change after completion; outputs must hold
        for (int i = 0; i < 8; i++) h_in[i] = $urandom;
        for (int t = 0; t < 64; t++) w_in[t] = $urandom;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold_hout%0d", c), h_out, DIG_ABC);
            check($sformatf("hold_done%0d", c), 256'(done), 256'h1);
        end

        // Asynchronous clear of a finished result
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_hout", h_out, 256'h0);
        check("async_done", 256'(done), 256'h0);

        check("sb_drained", 256'(exp_q.size()), 256'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
